pic_window_3x3: RTL

PIC_WINDOW_3X3 -- requirements
Module: pic_window_3x3

---
 rtl/conv_pkg.sv | 16 +
 rtl/pic_line_buf.sv | 27 ++
 rtl/pic_window_3x3.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the 3x3 pixel window generator.
// Optional feature macro: PIC_WIN_COORD_OUT_EN (adds window coordinate outputs).
package conv_pkg;

  localparam int IMG_W    = 28;
  localparam int IMG_H    = 28;
  localparam int PIX_W    = 16;
  localparam int KERNEL_K = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pic_line_buf.sv
// Enabled shift delay line: o_data is the sample written DEPTH enables ago.
// Storage is intentionally not reset; downstream logic never exposes stale data.
module pic_line_buf #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Shift one position per enable so the tap lags by exactly DEPTH accepted samples
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign o_data = r_mem[DEPTH-1];

endmodule

// File: rtl/pic_window_3x3.sv
// Streaming 3x3 window generator over a raster-order image.
// Optional feature macro: PIC_WIN_COORD_OUT_EN adds win_row/win_col outputs
// carrying the top-left coordinate of each valid window.
module pic_window_3x3 #(
  parameter int IMG_W = conv_pkg::IMG_W,
  parameter int IMG_H = conv_pkg::IMG_H,
  parameter int PIX_W = conv_pkg::PIX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pic_in_valid,
  input  logic [PIX_W-1:0]   data_pic,
  output logic               win_valid,
  output logic [9*PIX_W-1:0] win_data,
  output logic               frame_done,
`ifdef PIC_WIN_COORD_OUT_EN
  output logic [4:0]         win_row,
  output logic [4:0]         win_col,
`endif
  output logic               busy
);

  import conv_pkg::*;

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0]   r_colCnt;
  logic [ROW_W-1:0]   r_rowCnt;
  logic               w_lastCol;
  logic               w_lastRow;
  logic               w_lastPix;
  logic               w_winReady;
  logic [PIX_W-1:0]   w_lb1Out;
  logic [PIX_W-1:0]   w_lb2Out;
  logic [PIX_W-1:0]   r_win     [KERNEL_K][KERNEL_K];
  logic [PIX_W-1:0]   w_nextWin [KERNEL_K][KERNEL_K];
  logic [9*PIX_W-1:0] w_nextFlat;
  logic               r_winValid;
  logic [9*PIX_W-1:0] r_winData;
  logic               r_frameDone;
  logic               r_busy;
  state_t             r_state;

  assign w_lastCol  = (r_colCnt == COL_W'(IMG_W - 1));
  assign w_lastRow  = (r_rowCnt == ROW_W'(IMG_H - 1));
  assign w_lastPix  = w_lastCol && w_lastRow;
  // Windows touching column 0/1 would mix the tail of the previous row, and
  // rows 0/1 would pull line-buffer data from an earlier frame or partial frame.
  assign w_winReady = (r_rowCnt >= ROW_W'(2)) && (r_colCnt >= COL_W'(2));

  // Raster position of the pixel about to be accepted; wraps to (0,0) after the last pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_colCnt <= '0;
      r_rowCnt <= '0;
    end else if (pic_in_valid) begin
      if (w_lastCol) begin
        r_colCnt <= '0;
        r_rowCnt <= w_lastRow ? '0 : r_rowCnt + ROW_W'(1);
      end else begin
        r_colCnt <= r_colCnt + COL_W'(1);
      end
    end
  end

  pic_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lineBuf1 (
    .clk    (clk),
    .i_en   (pic_in_valid),
    .i_data (data_pic),
    .o_data (w_lb1Out)
  );

  pic_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lineBuf2 (
    .clk    (clk),
    .i_en   (pic_in_valid),
    .i_data (w_lb1Out),
    .o_data (w_lb2Out)
  );

  // Next window: shift left one column and append {two rows up, one row up, incoming pixel}
  always_comb begin
    for (int r = 0; r < KERNEL_K; r++) begin
      for (int c = 0; c < KERNEL_K - 1; c++) begin
        w_nextWin[r][c] = r_win[r][c+1];
      end
    end
    w_nextWin[0][KERNEL_K-1] = w_lb2Out;
    w_nextWin[1][KERNEL_K-1] = w_lb1Out;
    w_nextWin[2][KERNEL_K-1] = data_pic;
  end

  // Flatten into the output layout: element (r,c) at slot 3r+c, newest pixel in the top slot
  always_comb begin
    w_nextFlat = '0;
    for (int r = 0; r < KERNEL_K; r++) begin
      for (int c = 0; c < KERNEL_K; c++) begin
        w_nextFlat[PIX_W*(KERNEL_K*r+c) +: PIX_W] = w_nextWin[r][c];
      end
    end
  end

  // Working window registers advance only on accepted pixels, so input gaps are invisible
  always_ff @(posedge clk) begin
    if (pic_in_valid) begin
      r_win <= w_nextWin;
    end
  end

  // Output window is captured only for fully in-frame windows and otherwise held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_winValid <= 1'b0;
      r_winData  <= '0;
    end else begin
      r_winValid <= pic_in_valid && w_winReady;
      if (pic_in_valid && w_winReady) begin
        r_winData <= w_nextFlat;
      end
    end
  end

`ifdef PIC_WIN_COORD_OUT_EN
  logic [4:0] r_winRow;
  logic [4:0] r_winCol;

  // Top-left coordinate of the captured window, updated together with the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_winRow <= '0;
      r_winCol <= '0;
    end else if (pic_in_valid && w_winReady) begin
      r_winRow <= 5'(r_rowCnt - ROW_W'(2));
      r_winCol <= 5'(r_colCnt - COL_W'(2));
    end
  end

  assign win_row = r_winRow;
  assign win_col = r_winCol;
`endif

  // Frame FSM with registered busy/frame_done; a pixel arriving in DONE starts the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_frameDone <= 1'b0;
          if (pic_in_valid) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          if (pic_in_valid && w_lastPix) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_frameDone <= 1'b1;
          end else begin
            r_busy      <= 1'b1;
            r_frameDone <= 1'b0;
          end
        end
        DONE: begin
          r_frameDone <= 1'b0;
          if (pic_in_valid) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_frameDone <= 1'b0;
        end
      endcase
    end
  end

  assign win_valid  = r_winValid;
  assign win_data   = r_winData;
  assign frame_done = r_frameDone;
  assign busy       = r_busy;

endmodule
